// File: rtl/btn_input_ctrl.sv
// Push-button conditioning for the pixel-clock domain.
// Each channel runs its own two-flop synchroniser, counter-based debouncer,
// press/release strobe generator and optional auto-repeat strobe generator.
// Channels share no state, so simultaneous presses give simultaneous strobes.
module btn_input_ctrl #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int REPEAT_DELAY    = 32500000,
   parameter int REPEAT_PERIOD   = 6500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   // Debounce counter only ever has to reach DEBOUNCE_CYCLES-1 before the level flips
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Repeat counter is a down-counter loaded with DELAY-1 or PERIOD-1
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic            sync_p0;
      logic            sync_p1;
      logic            level_q;
      logic            press_q;
      logic            release_q;
      logic [DB_W-1:0] db_cnt;
      logic            flip;

      // The debounced level changes on this edge: the synchronised input has
      // disagreed with the level for a full qualification window.
      assign flip = (sync_p1 != level_q) && (db_cnt == DB_LAST);

      // Synchroniser, debounce counter, level register and edge strobes
      always_ff @(posedge clk) begin
         if (rst) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            db_cnt    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            // stage p0 -> p1: two-flop synchroniser
            sync_p0   <= btn_raw[i];
            sync_p1   <= sync_p0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (sync_p1 == level_q) begin
               // agreement (or a glitch back) restarts qualification
               db_cnt <= '0;
            end else if (flip) begin
               db_cnt    <= '0;
               level_q   <= sync_p1;
               press_q   <= sync_p1;
               release_q <= ~sync_p1;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;

      if (REPEAT_DELAY > 0) begin : g_rpt
         logic [RPT_W-1:0] rpt_cnt;
         logic             rpt_q;

         // Auto-repeat: load on press, count down while held, clear when released
         always_ff @(posedge clk) begin
            if (rst) begin
               rpt_cnt <= '0;
               rpt_q   <= 1'b0;
            end else if (flip && sync_p1) begin
               // first repeat lands REPEAT_DELAY cycles after the press strobe
               rpt_cnt <= RPT_W'(REPEAT_DELAY - 1);
               rpt_q   <= 1'b0;
            end else if (!level_q || flip) begin
               // released (or releasing on this edge): no strobe, no progress kept
               rpt_cnt <= '0;
               rpt_q   <= 1'b0;
            end else if (rpt_cnt == '0) begin
               rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
               rpt_q   <= 1'b1;
            end else begin
               rpt_cnt <= rpt_cnt - 1'b1;
               rpt_q   <= 1'b0;
            end
         end

         assign btn_repeat[i] = rpt_q;
      end else begin : g_no_rpt
         assign btn_repeat[i] = 1'b0;
      end
   end

endmodule

// File: doc/btn_input_ctrl.md
Name: btn_input_ctrl

Overview:
- Input-side conditioning for the board push-buttons (up, down, centre) before they reach game logic in the pixel-clock domain.
- Per channel: two-flop synchroniser, counter-based debouncer, and one-cycle press/release strobes.
- Per channel: optional auto-repeat strobe while held, so paddle and menu logic never see raw, bouncing or asynchronous button levels.

Parameters:
- N_BTN, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 650000, consecutive cycles the synchronised input must differ from the debounced level before the level flips (10 ms at 65 MHz). Must be >= 1.
- REPEAT_DELAY, 32500000, cycles from press strobe to first repeat strobe (0.5 s). 0 disables repeat.
- REPEAT_PERIOD, 6500000, cycles between subsequent repeat strobes (0.1 s). Must be >= 1 when REPEAT_DELAY > 0.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button levels, active-high.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle strobe on debounced 0->1.
- btn_release  out  N_BTN  one-cycle strobe on debounced 1->0.
- btn_repeat  out  N_BTN  one-cycle auto-repeat strobe while held.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- While rst = 1 at a clock edge, all of the following clear to 0: sync flops, debounce counters, repeat counters, btn_level, btn_press, btn_release, btn_repeat.
- Reset asserted mid-debounce or mid-hold discards progress. After release of rst, a held button must re-qualify for a full DEBOUNCE_CYCLES window. It then produces a fresh btn_press.
- Channels are fully independent and share no counters.
- Synchroniser: two flops; s2 is btn_raw delayed by 2 edges.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == btn_level, the counter is 0.
  - Otherwise the counter increments each cycle.
  - On the edge where the counter == DEBOUNCE_CYCLES-1 and s2 still differs, btn_level <= s2 and the counter <= 0.
  - Any cycle with s2 == btn_level (a glitch) resets the counter to 0, so qualification restarts.
- Latency: btn_raw steady from edge k onward gives btn_level changing at edge k+1+DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES cycles never change btn_level.
- btn_press / btn_release are registered. They are high for exactly the one cycle in which btn_level first shows the new value, and low otherwise. They are never both high.
- Repeat counter: width sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - Loads on press.
  - Counts only while btn_level = 1.
  - Cleared when btn_level = 0.
- With P = the cycle btn_press is high, btn_repeat pulses at P+REPEAT_DELAY, then every REPEAT_PERIOD cycles, while btn_level stays 1.
- btn_repeat is never high in the same cycle as btn_press or btn_release, and never after release.
- REPEAT_DELAY = 0: btn_repeat is tied 0.
- Counters never wrap. The debounce counter saturates by construction because the level flips at its terminal count. The repeat counter reloads REPEAT_PERIOD-1 on each repeat strobe.
- Simultaneous presses on several channels produce simultaneous strobes.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, N_BTN=3):
- Reset: hold rst 3 cycles with btn_raw=3'b111 -> all outputs 0 during reset. After rst drops, btn_level[*] rises exactly 1+4 edges later with a single btn_press pulse per channel.
- Clean press: btn_raw[0] 0->1 at edge k, held 30 cycles -> btn_level[0]=1 from edge k+5. btn_press[0] high only at k+5. btn_repeat[0] high at k+15, k+20, k+25, k+30. Channels 1 and 2 stay 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 with 2-cycle high phases for 12 cycles, then stays 0 -> btn_level[1], btn_press[1], btn_release[1] never assert.
- Release: after the clean press, drop btn_raw[0] at edge m -> btn_level[0]=0 and btn_release[0] high at m+5 only. No btn_repeat at or after m+5.
- Short hold: btn_raw[2] high for 8 cycles -> one press, one release, zero repeats. Level high for exactly 8 cycles.
- Mid-hold reset: hold btn_raw[0] high, pulse rst for 1 cycle at the 12th cycle after press -> outputs clear on that edge. btn_press[0] reasserts 5 edges after rst deasserts. The repeat schedule restarts from the new press.
